dot_product_16: RTL and testbench

Dot-product sequencer for the MHA datapath. It accepts a stream of P_LEN operand pairs in signed Q1.15. Each pair is issued to the shared 16-bit pipelined multiplier, and the multiplier's product pulse is consumed. Products are summed in a wide signed accumulator, and one saturated Q1.15 result is emitted per vector. It sits directly upstream and downstream of the multiplier: it feeds multiplier I_VLD/I_M1/I_M2 and consumes multiplier O_VLD/O_PRODUCT.

---
 rtl/dot_product_16.sv | 135 +++++++++++++
 tb/tb_dot_product_16.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dot_product_16.sv
// Dot-product sequencer: issues P_LEN operand pairs one at a time to a shared
// pipelined multiplier, accumulates the returned products, emits a saturated Q1.15 sum.
module dot_product_16 #(
  parameter int P_LEN = 64,
  parameter int P_AW  = 22
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_START,
  input  logic        I_A_VLD,
  input  logic [15:0] I_A,
  input  logic [15:0] I_B,
  output logic        O_A_RDY,
  output logic        O_MUL_VLD,
  output logic [15:0] O_MUL_M1,
  output logic [15:0] O_MUL_M2,
  input  logic        I_MUL_VLD,
  input  logic [15:0] I_MUL_PRODUCT,
  output logic        O_VLD,
  output logic [15:0] O_SUM,
  output logic        O_OVF,
  output logic        O_BUSY
);

  localparam int CW = $clog2(P_LEN) + 1;
  localparam logic signed [P_AW-1:0] SAT_MAX = P_AW'(32767);
  localparam logic signed [P_AW-1:0] SAT_MIN = P_AW'(-32768);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic signed [P_AW-1:0] acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [15:0]            m1_q, m1_d, m2_q, m2_d;
  logic                   mvld_q, mvld_d;
  logic                   vld_q, vld_d;
  logic [15:0]            sum_q, sum_d;
  logic                   ovf_q, ovf_d;

  logic signed [P_AW-1:0] prod_ext;
  logic signed [P_AW-1:0] full;
  logic                   last;

  // Accumulator is wide enough that full never wraps; clamp only on publish.
  assign prod_ext = $signed({{(P_AW-16){I_MUL_PRODUCT[15]}}, I_MUL_PRODUCT});
  assign full     = acc_q + prod_ext;
  assign last     = (cnt_q == CW'(P_LEN - 1));

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      m1_q    <= '0;
      m2_q    <= '0;
      mvld_q  <= 1'b0;
      vld_q   <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      m1_q    <= m1_d;
      m2_q    <= m2_d;
      mvld_q  <= mvld_d;
      vld_q   <= vld_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    m1_d    = m1_q;
    m2_d    = m2_q;
    mvld_d  = 1'b0;
    vld_d   = 1'b0;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (I_START) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (I_A_VLD) begin
          m1_d    = I_A;
          m2_d    = I_B;
          mvld_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Product arrival is the only trusted event; latency is not assumed.
        if (I_MUL_VLD) begin
          acc_d = full;
          cnt_d = cnt_q + CW'(1);
          if (last) begin
            state_d = S_IDLE;
            vld_d   = 1'b1;
            if (full > SAT_MAX) begin
              sum_d = 16'h7FFF;
              ovf_d = 1'b1;
            end else if (full < SAT_MIN) begin
              sum_d = 16'h8000;
              ovf_d = 1'b1;
            end else begin
              sum_d = full[15:0];
              ovf_d = 1'b0;
            end
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign O_A_RDY   = (state_q == S_FETCH);
  assign O_BUSY    = (state_q != S_IDLE);
  assign O_MUL_VLD = mvld_q;
  assign O_MUL_M1  = m1_q;
  assign O_MUL_M2  = m2_q;
  assign O_VLD     = vld_q;
  assign O_SUM     = sum_q;
  assign O_OVF     = ovf_q;

endmodule

// File: tb/tb_dot_product_16.sv
// Directed + randomized bench for dot_product_16 (P_LEN=4); plays the multiplier
// with random latency and checks against a plain-arithmetic dot-product model.
module tb_dot_product_16;
  localparam int LEN = 4;
  localparam int AW  = 18;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        a_vld = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        mul_vld_in = 1'b0;
  logic [15:0] prod = '0;

  logic        a_rdy, mul_vld, vld, ovf, busy;
  logic [15:0] m1, m2, sum;

  dot_product_16 #(.P_LEN(LEN), .P_AW(AW)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_START(start), .I_A_VLD(a_vld),
    .I_A(a), .I_B(b), .O_A_RDY(a_rdy), .O_MUL_VLD(mul_vld),
    .O_MUL_M1(m1), .O_MUL_M2(m2), .I_MUL_VLD(mul_vld_in),
    .I_MUL_PRODUCT(prod), .O_VLD(vld), .O_SUM(sum), .O_OVF(ovf),
    .O_BUSY(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] va[LEN];
  logic [15:0] vb[LEN];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Q1.15 multiply as the shared multiplier performs it (truncate toward zero).
  function automatic logic [15:0] qmul(input logic [15:0] x, input logic [15:0] y);
    int sx, sy, p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    p  = (sx * sy) / 32768;
    return p[15:0];
  endfunction

  // {ovf, sum} for the vector held in va/vb.
  function automatic logic [16:0] ref_result();
    int s;
    logic [15:0] pr;
    s = 0;
    for (int i = 0; i < LEN; i++) begin
      pr = qmul(va[i], vb[i]);
      s += int'($signed(pr));
    end
    if (s > 32767)       return {1'b1, 16'h7FFF};
    else if (s < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, s[15:0]};
  endfunction

  task automatic chk_reset_outs(input string nm);
    chk({nm, ":rdy"},   a_rdy,   0);
    chk({nm, ":mvld"},  mul_vld, 0);
    chk({nm, ":m1"},    m1,      0);
    chk({nm, ":m2"},    m2,      0);
    chk({nm, ":vld"},   vld,     0);
    chk({nm, ":sum"},   sum,     0);
    chk({nm, ":ovf"},   ovf,     0);
    chk({nm, ":busy"},  busy,    0);
  endtask

  task automatic run_vector(input string nm, input int stall_at, input bit poke_start,
                            input int rst_at);
    logic [16:0] exp_r;
    int lat;
    exp_r = ref_result();
    start = 1'b1; tick; start = 1'b0;
    chk({nm, ":busy_go"}, busy, 1);
    chk({nm, ":rdy_go"},  a_rdy, 1);
    for (int i = 0; i < LEN; i++) begin
      if (i == stall_at)
        for (int s = 0; s < 10; s++) begin
          tick;
          chk({nm, ":stall_mvld"}, mul_vld, 0);
          chk({nm, ":stall_rdy"},  a_rdy,   1);
        end
      a = va[i]; b = vb[i]; a_vld = 1'b1; tick; a_vld = 1'b0;
      a = $urandom; b = $urandom;
      chk({nm, ":mvld"}, mul_vld, 1);
      chk({nm, ":m1"},   m1, va[i]);
      chk({nm, ":m2"},   m2, vb[i]);
      chk({nm, ":rdy_w"}, a_rdy, 0);
      if (poke_start && i == 1) begin
        start = 1'b1; tick; start = 1'b0;
        chk({nm, ":poke_busy"}, busy, 1);
        chk({nm, ":poke_rdy"},  a_rdy, 0);
        chk({nm, ":poke_mvld"}, mul_vld, 0);
      end
      lat = $urandom_range(1, 4);
      for (int w = 1; w < lat; w++) begin
        tick;
        chk({nm, ":mvld_once"}, mul_vld, 0);
        chk({nm, ":m1_hold"},   m1, va[i]);
        chk({nm, ":m2_hold"},   m2, vb[i]);
      end
      if (i == rst_at) begin
        rst_n = 1'b0; #1;
        chk_reset_outs({nm, ":rst"});
        tick; rst_n = 1'b1; tick;
        prod = 16'h7FFF; mul_vld_in = 1'b1; tick; mul_vld_in = 1'b0;
        chk({nm, ":stray_busy"}, busy, 0);
        chk({nm, ":stray_vld"},  vld, 0);
        return;
      end
      prod = qmul(va[i], vb[i]); mul_vld_in = 1'b1; tick; mul_vld_in = 1'b0;
      prod = $urandom;
      if (i < LEN - 1) begin
        chk({nm, ":rdy_next"}, a_rdy, 1);
        chk({nm, ":vld_early"}, vld, 0);
      end else begin
        chk({nm, ":vld"},  vld,  1);
        chk({nm, ":busy"}, busy, 0);
        chk({nm, ":sum"},  sum,  exp_r[15:0]);
        chk({nm, ":ovf"},  ovf,  exp_r[16]);
      end
    end
    tick;
    chk({nm, ":vld_pulse"}, vld, 0);
    chk({nm, ":sum_hold"},  sum, exp_r[15:0]);
    chk({nm, ":ovf_hold"},  ovf, exp_r[16]);
  endtask

  task automatic load_d1;
    for (int i = 0; i < LEN; i++) begin va[i] = 16'h4000; vb[i] = 16'h2000; end
  endtask

  initial begin
    tick; tick;
    chk_reset_outs("reset");
    rst_n = 1'b1; tick;
    chk_reset_outs("post_reset");

    load_d1;
    run_vector("d1", -1, 1'b0, -1);

    va = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vb = '{16'h2000, 16'hE000, 16'h1000, 16'h0000};
    run_vector("d2_mixed", -1, 1'b0, -1);

    for (int i = 0; i < LEN; i++) begin va[i] = 16'h4000; vb[i] = 16'h4000; end
    run_vector("d3_satpos", -1, 1'b0, -1);

    for (int i = 0; i < LEN; i++) begin va[i] = 16'hC000; vb[i] = 16'h7FFF; end
    run_vector("d4_satneg", -1, 1'b0, -1);

    for (int i = 0; i < LEN; i++) begin va[i] = $urandom; vb[i] = $urandom; end
    run_vector("bp", 1, 1'b1, -1);

    prod = 16'h7FFF; mul_vld_in = 1'b1; tick; mul_vld_in = 1'b0;
    chk("idle_stray_busy", busy, 0);
    chk("idle_stray_vld",  vld, 0);
    load_d1;
    run_vector("after_stray", -1, 1'b0, -1);

    run_vector("rst_mid", -1, 1'b0, 2);
    load_d1;
    run_vector("after_rst", -1, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < LEN; i++) begin va[i] = $urandom; vb[i] = $urandom; end
      run_vector("rand", -1, 1'b0, -1);
    end
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < LEN; i++) begin
        va[i] = 16'($urandom_range(16'h6000, 16'h7FFF));
        vb[i] = (r[0]) ? 16'(16'h0000 - 16'($urandom_range(16'h6000, 16'h7FFF)))
                       : 16'($urandom_range(16'h6000, 16'h7FFF));
      end
      run_vector("rand_sat", -1, 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
